// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants and FSM state encoding for the 8N1 UART
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 87;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} uart_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop input synchroniser and mid-bit sampling
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic                 rx_dv,
  output logic [DATA_BITS-1:0] rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  logic [1:0] sync;
  logic rx;
  uart_state_e state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shift;
  assign rx = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync    <= 2'b11;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      rx_dv   <= 1'b0;
      rx_byte <= '0;
    end else begin
      sync  <= {sync[0], rx_serial};
      rx_dv <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx) state <= START;
        end
        // re-check the line at mid start bit so short glitches are dropped
        START:
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= rx ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt        <= '0;
            shift[idx] <= rx;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end
        STOP:
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt   <= '0;
            state <= CLEANUP;
            if (rx) begin
              rx_byte <= shift;
              rx_dv   <= 1'b1;
            end
          end
        CLEANUP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter, start/data/stop bits each CLKS_PER_BIT cycles
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_dv,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_active,
  output logic                 tx_serial,
  output logic                 tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  uart_state_e state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] data;
  // line level is registered one cycle behind the state, so every bit spans exactly CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data      <= '0;
      tx_active <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          cnt       <= '0;
          idx       <= '0;
          if (tx_dv) begin
            data      <= tx_byte;
            tx_active <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          tx_serial <= 1'b0;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          tx_serial <= data[idx];
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt <= '0;
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end
        end
        STOP: begin
          tx_serial <= 1'b1;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt   <= '0;
            state <= CLEANUP;
          end
        end
        CLEANUP: begin
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART, independent RX and TX sharing clock and reset
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  logic [1:0] rst_pipe;
  logic rst_n;
  // reset asserts immediately but releases on a clock edge
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) rst_pipe <= 2'b00;
    else rst_pipe <= {rst_pipe[0], 1'b1};
  assign rst_n = rst_pipe[1];
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (i_Clock),
    .rst_n    (rst_n),
    .rx_serial(i_Rx_Serial),
    .rx_dv    (o_Rx_DV),
    .rx_byte  (o_Rx_Byte)
  );
  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (i_Clock),
    .rst_n    (rst_n),
    .tx_dv    (i_Tx_DV),
    .tx_byte  (i_Tx_Byte),
    .tx_active(o_Tx_Active),
    .tx_serial(o_Tx_Serial),
    .tx_done  (o_Tx_Done)
  );
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: randomized self-checking bench against a frame-level UART model
`timescale 1ns/1ps
module tb_uart_transceiver;
  localparam int C = 87;
  localparam int BIT_NS = C * 100;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_drv = 1'b1;
  logic lb = 1'b0;
  logic tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic rx_dv, tx_active, tx_serial, tx_done;
  logic [7:0] rx_byte;
  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #50 clk = ~clk;

  uart_transceiver #(.CLKS_PER_BIT(C)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Rx_Serial(lb ? tx_serial : rx_drv),
    .o_Rx_DV    (rx_dv),
    .o_Rx_Byte  (rx_byte),
    .i_Tx_DV    (tx_dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Active(tx_active),
    .o_Tx_Serial(tx_serial),
    .o_Tx_Done  (tx_done)
  );

  always @(negedge clk) begin
    if (rx_dv) got_q.push_back(rx_byte);
    if (tx_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int bit_ns, input int extra_ns);
    rx_drv = 1'b0;
    #(bit_ns + extra_ns);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(bit_ns);
    end
    rx_drv = stop_ok;
    if (stop_ok) begin
      exp_q.push_back(b);
      #(bit_ns);
    end else begin
      #(bit_ns * 3 / 4);
      rx_drv = 1'b1;
      #(bit_ns / 4);
    end
    rx_drv = 1'b1;
    #(2 * bit_ns);
  endtask

  task automatic tx_frame(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    logic [7:0] rec;
    int werr, aerr, derr, bit_i;
    frame = {1'b1, b, 1'b0};
    rec = 8'h00;
    werr = 0;
    aerr = 0;
    derr = 0;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv = 1'b0;
    tx_byte = ~b;
    check({tag, "_acc_active"}, tx_active, 1);
    check({tag, "_acc_serial"}, tx_serial, 1);
    for (int n = 1; n <= 10 * C; n++) begin
      @(negedge clk);
      if (n == 5) begin
        tx_dv = 1'b1;
        tx_byte = 8'($urandom);
      end else tx_dv = 1'b0;
      bit_i = (n - 1) / C;
      if (tx_serial !== frame[bit_i]) werr++;
      if (tx_active !== 1'b1) aerr++;
      if (tx_done !== 1'b0) derr++;
      if ((n - 1) % C == C / 2 && bit_i >= 1 && bit_i <= 8) rec[bit_i-1] = tx_serial;
    end
    @(negedge clk);
    check({tag, "_done"}, tx_done, 1);
    check({tag, "_end_active"}, tx_active, 0);
    check({tag, "_end_serial"}, tx_serial, 1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, tx_done, 0);
    check({tag, "_wave_errs"}, werr, 0);
    check({tag, "_active_errs"}, aerr, 0);
    check({tag, "_early_done"}, derr, 0);
    check({tag, "_decoded"}, rec, b);
  endtask

  task automatic tx_send(input logic [7:0] b);
    int t;
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tx_active && t < 10);
    tx_dv = 1'b0;
    check("lb_accept", tx_active, 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tx_done && t < 12 * C);
    check("lb_done", tx_done, 1);
  endtask

  initial begin
    #(8_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, prev;
    logic [7:0] lb_bytes[4];
    int d0;
    lb_bytes = '{8'h00, 8'hFF, 8'h55, 8'hA5};
    #10 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    check("rst_rx_dv", rx_dv, 0);
    check("rst_rx_byte", rx_byte, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();
    n_done = 0;

    tx_frame(8'hAB, "tx_ab");
    check("tx_ab_done_cnt", n_done, 1);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), "tx_rnd");

    send_rx(8'h3F, 1'b1, 8600, 1000);
    check_rx("rx_3f");
    check("rx_3f_hold", rx_byte, 8'h3F);
    prev = 8'h3F;
    for (int i = 0; i < 4; i++) begin
      prev = 8'($urandom);
      send_rx(prev, 1'b1, int'($urandom_range(8600, 8800)), int'($urandom_range(0, 1000)));
      check_rx("rx_rnd");
    end

    send_rx(8'h12, 1'b0, BIT_NS, 0);
    check_rx("frm_err");
    check("frm_err_hold", rx_byte, prev);
    send_rx(8'h34, 1'b1, BIT_NS, 0);
    check_rx("frm_next");
    check("frm_next_byte", rx_byte, 8'h34);

    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * C) @(negedge clk);
    check_rx("glitch");
    send_rx(8'hC3, 1'b1, BIT_NS, 0);
    check_rx("glitch_next");

    lb = 1'b1;
    d0 = n_done;
    for (int i = 0; i < 8; i++) begin
      b = (i < 4) ? lb_bytes[i] : 8'($urandom);
      exp_q.push_back(b);
      tx_send(b);
    end
    repeat (2 * C) @(negedge clk);
    check_rx("loop");
    check("loop_done_cnt", n_done - d0, 8);
    lb = 1'b0;
    repeat (C) @(negedge clk);

    d0 = n_done;
    b = 8'($urandom);
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'($urandom);
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (C - 1) @(negedge clk);
    rx_drv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (C) @(negedge clk);
      rx_drv = b[i];
    end
    repeat (C / 2) @(negedge clk);
    check("mid_active_pre", tx_active, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_serial", tx_serial, 1);
    check("mid_rst_active", tx_active, 0);
    check("mid_rst_rx_byte", rx_byte, 0);
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("mid_rst_no_done", n_done, d0);
    check("mid_rst_idle_serial", tx_serial, 1);
    check_rx("mid_rst_no_dv");
    tx_frame(8'h81, "tx_81");
    send_rx(8'h81, 1'b1, BIT_NS, 0);
    check_rx("rx_81");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART (8 data bits, no parity, 1 stop bit) with independent receive and transmit paths sharing one clock and one reset.
- Sits between the host-side byte interface (valid-strobe handshake) and the external serial RX/TX pins.
- Baud rate is set by the fixed parameter CLKS_PER_BIT (for example, 10 MHz / 115200 = 87).

Parameters:
- CLKS_PER_BIT, 87, number of i_Clock cycles per serial bit; legal range 4..65535.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_Rx_Serial  in  1  serial input; idle high; asynchronous to i_Clock.
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte holds a newly received byte.
- o_Rx_Byte  out  8  last correctly framed received byte.
- i_Tx_DV  in  1  transmit request strobe; sampled only while TX is idle.
- i_Tx_Byte  in  8  byte to send; captured on the accepted i_Tx_DV.
- o_Tx_Active  out  1  high while a TX frame is in progress.
- o_Tx_Serial  out  1  serial output; idle high.
- o_Tx_Done  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - o_Tx_Serial=1; o_Rx_DV, o_Rx_Byte, o_Tx_Active, o_Tx_Done = 0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; o_Tx_Serial returns high and no DV/Done pulse is emitted.
- RX synchronisation: i_Rx_Serial passes through a 2-flop synchroniser. All RX timing below is relative to the synchronised signal.
- RX FSM states: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: a low level on the line moves to START; the bit counter clears.
  - START: count to (CLKS_PER_BIT-1)/2 (mid-bit).
    - If the line is still low: the start bit is valid; reset the counter and go to DATA.
    - Otherwise: it was a glitch; return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first. After 8 samples go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample the line.
    - If 1: load o_Rx_Byte and pulse o_Rx_DV high for exactly one cycle.
    - If 0 (framing error): no DV pulse; o_Rx_Byte unchanged.
    - Either way go to CLEANUP.
  - CLEANUP: one cycle, then IDLE. A new start bit may be detected on the next cycle.
  - Mid-bit sampling must tolerate an early/late edge of up to ±(CLKS_PER_BIT/2 - 2) clocks accumulated over the frame. This includes a start bit stretched by about 10 clocks.
  - o_Rx_Byte holds its value until the next good frame.
- TX FSM states: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: o_Tx_Serial=1.
    - If i_Tx_DV=1 at edge k: latch i_Tx_Byte and go to START.
    - o_Tx_Active=1 from edge k.
    - o_Tx_Serial=0 from edge k+1 (start bit).
  - Each bit (start, 8 data LSB-first, stop=1) is held for exactly CLKS_PER_BIT cycles.
  - At the end of the stop bit (edge k+1+10*CLKS_PER_BIT):
    - o_Tx_Done pulses high for one cycle.
    - o_Tx_Active falls.
    - The FSM enters CLEANUP for one cycle, then IDLE.
  - The earliest next accepted i_Tx_DV is the cycle after CLEANUP, which gives back-to-back frames with no idle gap beyond that one cycle.
  - i_Tx_DV while not IDLE is ignored; the latched byte is unaffected by changes on i_Tx_Byte mid-frame.
- RX and TX are fully independent. Simultaneous activity, including loopback of o_Tx_Serial to i_Rx_Serial, must work.
- Counter width is $clog2(CLKS_PER_BIT); the bit index is 3 bits and wraps 7 -> done.

Decomposition:
- Package uart_pkg:
  - RX/TX state enums (IDLE, START, DATA, STOP, CLEANUP).
  - DATA_BITS=8 constant.
  - Default CLKS_PER_BIT constant.
- Sub-modules uart_rx_core and uart_tx_core (one per direction), instantiated by uart_transceiver. The 2-flop synchroniser lives inside uart_rx_core.

Test Plan:
- TX 0xAB, CLKS_PER_BIT=87, 10 MHz clock -> o_Tx_Serial emits 0,1,1,0,1,0,1,0,1,1, each bit 87 clocks; o_Tx_Done pulses once 871 clocks after the DV edge; o_Tx_Active is high throughout the frame.
- RX 0x3F at a 8600 ns bit period, with the start bit stretched by 1000 ns -> one o_Rx_DV pulse; o_Rx_Byte=0x3F after the stop bit.
- Loopback o_Tx_Serial->i_Rx_Serial, sending 0x00, 0xFF, 0x55, 0xA5 back-to-back (each new DV one cycle after Done) -> four DV pulses with matching bytes in order; no extra pulses.
- Framing error: RX 0x12 with the stop bit driven 0 -> no o_Rx_DV; o_Rx_Byte keeps its previous value. Next good frame 0x34 -> o_Rx_Byte=0x34.
- Start glitch: low pulse of 20 clocks on i_Rx_Serial -> no DV; FSM back in IDLE; a following 0xC3 frame is received correctly.
- Reset mid-TX at bit 4 and mid-RX at bit 3 -> o_Tx_Serial=1, o_Tx_Active=0, no Done/DV pulses; next TX 0x81 and RX 0x81 complete correctly.
